// File: rtl/line_code_pkg.sv
// Shared definitions for the line-code encoder: per-bit code selectors and
// the handshake FSM state type.
package line_code_pkg;

   localparam logic [1:0] MODE_MANCH  = 2'd0;
   localparam logic [1:0] MODE_FM0    = 2'd1;
   localparam logic [1:0] MODE_MILLER = 2'd2;
   localparam logic [1:0] MODE_FM1    = 2'd3;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/bit_period_ctr.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running and decodes the
// boundary, mid-bit and last-cycle strobes.
module bit_period_ctr #(
   parameter int CLKS_PER_BIT = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic first,
   output logic mid,
   output logic last
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] MID_C  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // mid fires one cycle early so the registered line shows the change at cnt == HALF
   assign mid  = run && (cnt == MID_C);
   assign last = run && (cnt == LAST_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         first <= 1'b0;
      end else begin
         first <= start;
         if (start || !run || (cnt == LAST_C)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/line_code_enc.sv
// Serial line-code encoder: one bit per CLKS_PER_BIT cycles over valid/ready,
// coded per bit as Manchester, FM0, Miller/MFM or FM1 onto a single wire.
module line_code_enc
   import line_code_pkg::*;
#(
   parameter int CLKS_PER_BIT = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   input  logic [1:0] mode,
   output logic       line_out,
   output logic       busy,
   output logic       bit_start,
   output logic       underrun
);

   state_t     state;
   logic       cur_bit;
   logic [1:0] cur_mode;
   logic       prev_bit;
   logic       p_eff;
   logic       accept;
   logic       run;
   logic       first;
   logic       mid;
   logic       last;

   // Next line level for a boundary (at_mid = 0) or mid-bit (at_mid = 1) action.
   function automatic logic next_level(input logic       lvl,
                                       input logic       b,
                                       input logic       p,
                                       input logic [1:0] md,
                                       input logic       at_mid);
      logic nl;
      nl = lvl;
      case (md)
         MODE_MANCH:  nl = at_mid ? b : ~b;
         MODE_FM0:    nl = at_mid ? (lvl ^ ~b) : ~lvl;
         MODE_MILLER: nl = at_mid ? (lvl ^ b) : (lvl ^ (~b & ~p));
         default:     nl = at_mid ? (lvl ^ b) : ~lvl;
      endcase
      return nl;
   endfunction

   assign run       = (state == ACTIVE);
   assign in_ready  = (state == IDLE) || last;
   assign accept    = in_valid && in_ready;
   assign bit_start = first;

   // On a back-to-back boundary the period that is just closing is the history bit.
   assign p_eff = last ? cur_bit : prev_bit;

   bit_period_ctr #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .run   (run),
      .first (first),
      .mid   (mid),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         line_out <= 1'b0;
         busy     <= 1'b0;
         underrun <= 1'b0;
         prev_bit <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (last) begin
            prev_bit <= cur_bit;
         end
         if (accept) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            line_out <= next_level(line_out, in_bit, p_eff, mode, 1'b0);
         end else if (last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            underrun <= 1'b1;
         end else if (mid) begin
            line_out <= next_level(line_out, cur_bit, prev_bit, cur_mode, 1'b1);
         end
      end
   end

   // Bit and code are held for the whole period; only acceptance reloads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         cur_bit  <= in_bit;
         cur_mode <= mode;
      end
   end

endmodule

// File: tb/tb_line_code_enc.sv
// Bench for line_code_enc: a per-cycle expected timeline is built from the
// line-code rules, then the DUT is driven from it and compared every cycle.
module tb_line_code_enc;
   import line_code_pkg::*;

   localparam int CPB  = 8;
   localparam int HALF = CPB / 2;
   localparam int MAXC = 4096;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       in_ready, line_out, busy, bit_start, underrun;

   always #5 clk = ~clk;

   line_code_enc #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .mode      (mode),
      .line_out  (line_out),
      .busy      (busy),
      .bit_start (bit_start),
      .underrun  (underrun)
   );

   logic       drv_rst[MAXC], drv_valid[MAXC], drv_bit[MAXC];
   logic [1:0] drv_mode[MAXC];
   logic       e_line[MAXC], e_busy[MAXC], e_bs[MAXC], e_ur[MAXC], e_rdy[MAXC];
   bit         chk[MAXC];

   int   tl = 0;
   logic m_line = 1'b0, m_prev = 1'b0, pend_ur = 1'b0;
   int   checks = 0, failures = 0;

   typedef struct {
      int    cyc;
      int    sig;
      logic  val;
      string tag;
   } dchk_t;
   dchk_t dq[$];

   task automatic add_d(input int c, input int s, input logic v, input string tag);
      dchk_t d;
      d.cyc = c; d.sig = s; d.val = v; d.tag = tag;
      dq.push_back(d);
   endtask

   task automatic guard(input int c);
      if (c >= MAXC) begin
         $display("FAIL timeline_overflow cycle=%0d limit=%0d", c, MAXC);
         $fatal(1, "timeline overflow");
      end
   endtask

   // Levels of the two half-periods for one bit, straight from the code rules.
   task automatic rule_levels(input logic [1:0] m, input logic b, input logic p,
                              input logic l, output logic h1, output logic h2);
      case (m)
         MODE_MANCH:  begin h1 = ~b; h2 = b; end
         MODE_FM0:    begin h1 = ~l; h2 = b ? h1 : ~h1; end
         MODE_MILLER: begin h1 = (!b && !p) ? ~l : l; h2 = b ? ~h1 : h1; end
         default:     begin h1 = ~l; h2 = b ? ~h1 : h1; end
      endcase
   endtask

   task automatic put_idle(input int c, input logic v, input logic b, input logic [1:0] md);
      guard(c);
      drv_rst[c] = 1'b0; drv_valid[c] = v; drv_bit[c] = b; drv_mode[c] = md;
      e_line[c] = m_line; e_busy[c] = 1'b0; e_bs[c] = 1'b0;
      e_ur[c] = pend_ur; e_rdy[c] = 1'b1; chk[c] = 1'b1;
      pend_ur = 1'b0;
   endtask

   task automatic put_active(input int c, input int j, input logic lvl);
      guard(c);
      drv_rst[c] = 1'b0; drv_valid[c] = 1'b0;
      drv_bit[c] = 1'($urandom); drv_mode[c] = 2'($urandom);
      e_line[c] = lvl; e_busy[c] = 1'b1; e_bs[c] = (j == 0);
      e_ur[c] = 1'b0; e_rdy[c] = (j == CPB - 1); chk[c] = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         put_idle(tl, 1'b0, 1'($urandom), 2'($urandom));
         tl++;
      end
   endtask

   task automatic reset_cycles(input int n);
      m_line = 1'b0; m_prev = 1'b0; pend_ur = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) put_idle(tl, 1'b0, 1'b0, 2'd0);
         guard(tl);
         drv_rst[tl] = 1'b1; drv_valid[tl] = 1'b0;
         tl++;
      end
   endtask

   // Stream of bits: bit k accepted at t+k*CPB, offered lq[k] cycles early.
   task automatic burst(input logic bq[$], input logic [1:0] mq[$], input int lq[$], output int t);
      logic h1, h2;
      int   a;
      t = tl;
      put_idle(t, 1'b1, bq[0], mq[0]);
      for (int k = 0; k < bq.size(); k++) begin
         a = t + k * CPB;
         rule_levels(mq[k], bq[k], m_prev, m_line, h1, h2);
         for (int j = 0; j < CPB; j++) put_active(a + 1 + j, j, (j < HALF) ? h1 : h2);
         m_line = h2;
         m_prev = bq[k];
      end
      for (int k = 1; k < bq.size(); k++) begin
         for (int c = t + k * CPB - lq[k]; c <= t + k * CPB; c++) begin
            drv_valid[c] = 1'b1; drv_bit[c] = bq[k]; drv_mode[c] = mq[k];
         end
      end
      tl = t + bq.size() * CPB + 1;
      pend_ur = 1'b1;
   endtask

   // One bit whose period is cut by a one-cycle reset at cnt == rc.
   task automatic burst_abort(input logic b, input logic [1:0] m, input int rc, output int t);
      logic h1, h2;
      t = tl;
      put_idle(t, 1'b1, b, m);
      rule_levels(m, b, m_prev, m_line, h1, h2);
      for (int j = 0; j <= rc; j++) put_active(t + 1 + j, j, (j < HALF) ? h1 : h2);
      tl = t + 1 + rc;
      reset_cycles(1);
   endtask

   task automatic check(input string tag, input int c, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, obs, exp);
      end
   endtask

   function automatic logic sig_val(input int s);
      case (s)
         0:       return line_out;
         1:       return busy;
         2:       return bit_start;
         3:       return underrun;
         default: return in_ready;
      endcase
   endfunction

   initial begin
      logic       bq[$];
      logic [1:0] mq[$];
      int         lq[$];
      int         t, r, n;

      for (int c = 0; c < MAXC; c++) begin
         drv_rst[c] = 1'b0; drv_valid[c] = 1'b0; drv_bit[c] = 1'b0; drv_mode[c] = 2'd0;
         chk[c] = 1'b0;
      end

      // Reset for three cycles, then the state right after it.
      reset_cycles(3);
      add_d(3, 0, 1'b0, "rst_line"); add_d(3, 1, 1'b0, "rst_busy");
      add_d(3, 4, 1'b1, "rst_ready"); add_d(3, 3, 1'b0, "rst_underrun");
      idle(2);

      // Miller 1,0,0,1 back-to-back from line 0.
      bq = '{1'b1, 1'b0, 1'b0, 1'b1};
      mq = '{MODE_MILLER, MODE_MILLER, MODE_MILLER, MODE_MILLER};
      lq = '{0, 0, 0, 0};
      burst(bq, mq, lq, t);
      add_d(t + 4, 0, 1'b0, "mil_pre_rise"); add_d(t + 5, 0, 1'b1, "mil_rise");
      add_d(t + 16, 0, 1'b1, "mil_hold"); add_d(t + 17, 0, 1'b0, "mil_fall");
      add_d(t + 28, 0, 1'b0, "mil_pre_rise2"); add_d(t + 29, 0, 1'b1, "mil_rise2");
      add_d(t + 32, 3, 1'b0, "mil_no_ur"); add_d(t + 33, 3, 1'b1, "mil_ur");
      idle(2);

      // FM0 0,0 from line 0.
      reset_cycles(3);
      idle(1);
      bq = '{1'b0, 1'b0}; mq = '{MODE_FM0, MODE_FM0}; lq = '{0, 0};
      burst(bq, mq, lq, t);
      add_d(t + 1, 0, 1'b1, "fm0_b0"); add_d(t + 5, 0, 1'b0, "fm0_m0");
      add_d(t + 9, 0, 1'b1, "fm0_b1"); add_d(t + 13, 0, 1'b0, "fm0_m1");
      idle(1);

      // Manchester single 1, then idle holding the line.
      bq = '{1'b1}; mq = '{MODE_MANCH}; lq = '{0};
      burst(bq, mq, lq, t);
      add_d(t + 1, 0, 1'b0, "man_h1a"); add_d(t + 4, 0, 1'b0, "man_h1b");
      add_d(t + 5, 0, 1'b1, "man_h2a"); add_d(t + 8, 0, 1'b1, "man_h2b");
      add_d(t + 9, 3, 1'b1, "man_ur"); add_d(t + 9, 0, 1'b1, "man_hold");
      add_d(t + 9, 1, 1'b0, "man_idle_busy");
      idle(2);

      // FM1 alternating with in_valid held high throughout.
      bq = '{1'b0, 1'b1, 1'b0, 1'b1};
      mq = '{MODE_FM1, MODE_FM1, MODE_FM1, MODE_FM1};
      lq = '{0, CPB - 1, CPB - 1, CPB - 1};
      burst(bq, mq, lq, t);
      add_d(t + 1, 2, 1'b1, "bp_bs0"); add_d(t + 2, 2, 1'b0, "bp_bs_gap");
      add_d(t + 9, 2, 1'b1, "bp_bs1"); add_d(t + 17, 2, 1'b1, "bp_bs2");
      add_d(t + 4, 4, 1'b0, "bp_not_ready"); add_d(t + 8, 4, 1'b1, "bp_ready");
      add_d(t + 16, 1, 1'b1, "bp_busy_cont"); add_d(t + 17, 3, 1'b0, "bp_no_ur");
      idle(1);

      // Reset in the middle of a Miller 1 that follows a completed Miller 1.
      reset_cycles(2);
      idle(1);
      bq = '{1'b1}; mq = '{MODE_MILLER}; lq = '{0};
      burst(bq, mq, lq, t);
      idle(1);
      burst_abort(1'b1, MODE_MILLER, 3, t);
      add_d(t + 5, 0, 1'b0, "abort_line"); add_d(t + 5, 1, 1'b0, "abort_busy");
      add_d(t + 5, 4, 1'b1, "abort_ready"); add_d(t + 5, 3, 1'b0, "abort_no_ur");
      idle(2);
      bq = '{1'b0}; mq = '{MODE_MILLER}; lq = '{0};
      burst(bq, mq, lq, t);
      add_d(t + 1, 0, 1'b1, "abort_prev_cleared");
      idle(1);

      // Randomized streams, gaps, early offers and occasional aborts.
      for (r = 0; r < 40; r++) begin
         if (r % 10 == 9) begin
            burst_abort(1'($urandom), 2'($urandom), $urandom_range(0, CPB - 2), t);
            idle($urandom_range(0, 2));
         end else begin
            n = $urandom_range(1, 5);
            bq.delete(); mq.delete(); lq.delete();
            for (int k = 0; k < n; k++) begin
               bq.push_back(1'($urandom));
               mq.push_back(2'($urandom));
               lq.push_back((k == 0) ? 0 : $urandom_range(0, CPB - 1));
            end
            burst(bq, mq, lq, t);
            idle($urandom_range(0, 3));
         end
      end

      for (int c = 0; c < tl; c++) begin
         @(posedge clk);
         #1;
         rst = drv_rst[c]; in_valid = drv_valid[c]; in_bit = drv_bit[c]; mode = drv_mode[c];
         @(negedge clk);
         if (chk[c]) begin
            check("line_out", c, line_out, e_line[c]);
            check("busy", c, busy, e_busy[c]);
            check("bit_start", c, bit_start, e_bs[c]);
            check("underrun", c, underrun, e_ur[c]);
            check("in_ready", c, in_ready, e_rdy[c]);
         end
         foreach (dq[i]) begin
            if (dq[i].cyc == c) check(dq[i].tag, c, sig_val(dq[i].sig), dq[i].val);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
